ram_fifo_sync: RTL and testbench

//  Single-clock parametrised FIFO built on a simple dual-port RAM; successor to the dual-clock RAM.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_dp_sync.sv | 48 ++++
 rtl/ram_fifo_sync.sv | 123 ++++++++++++
 tb/tb_ram_fifo_sync.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, flag-bit indices and clog2 helper for the RAM FIFO
package ram_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_NUMBER = 3;

    localparam int FLAG_EMPTY = 0;
    localparam int FLAG_FULL  = 1;
    localparam int FLAG_AE    = 2;
    localparam int FLAG_AF    = 3;
    localparam int FLAG_OVF   = 4;
    localparam int FLAG_UNF   = 5;
    localparam int FLAG_W     = 6;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_dp_sync.sv
// rtl/ram_dp_sync.sv - simple dual-port RAM, one write port and one registered read port
module ram_dp_sync
    import ram_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUMBER = DEFAULT_NUMBER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [NUMBER-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [NUMBER-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // The array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading the old word on a same-address write is what lets a full FIFO read and write together.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_fifo_sync.sv
// rtl/ram_fifo_sync.sv - single-clock FIFO over ram_dp_sync with count, level and sticky error flags
module ram_fifo_sync
    import ram_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUMBER = DEFAULT_NUMBER,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    output logic [NUMBER:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    generate
        if (DEPTH != (1 << NUMBER) || clog2(DEPTH) != NUMBER) begin : g_bad_depth
            $error("ram_fifo_sync: DEPTH must equal 2**NUMBER");
        end
    endgenerate

    localparam logic [NUMBER:0] FULL_CNT = (NUMBER + 1)'(DEPTH);
    localparam logic [NUMBER:0] AF_CNT   = (NUMBER + 1)'(AF_LVL);
    localparam logic [NUMBER:0] AE_CNT   = (NUMBER + 1)'(AE_LVL);
    localparam logic [NUMBER:0] CNT_ONE  = (NUMBER + 1)'(1);
    localparam logic [NUMBER-1:0] PTR_ONE = NUMBER'(1);

    logic [NUMBER-1:0] wr_ptr_q, wr_ptr_d;
    logic [NUMBER-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUMBER:0]   count_q, count_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              data_valid_q, data_valid_d;
    logic              req_ok, wr_acc, rd_acc;

    // Reset wins over any request in the same cycle, so it also blocks the RAM write.
    assign req_ok = !cs_n && !reset;
    assign rd_acc = req_ok && rd_en && !flags_q[FLAG_EMPTY];
    assign wr_acc = req_ok && wr_en && (!flags_q[FLAG_FULL] || rd_acc);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_valid_d = rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Level flags follow next-state count so they line up with count every cycle.
    always_comb begin
        flags_d             = flags_q;
        flags_d[FLAG_EMPTY] = (count_d == '0);
        flags_d[FLAG_FULL]  = (count_d == FULL_CNT);
        flags_d[FLAG_AE]    = (count_d <= AE_CNT);
        flags_d[FLAG_AF]    = (count_d >= AF_CNT);
        flags_d[FLAG_OVF]   = flags_q[FLAG_OVF] | (req_ok & wr_en & !wr_acc);
        flags_d[FLAG_UNF]   = flags_q[FLAG_UNF] | (req_ok & rd_en & !rd_acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            count_q             <= '0;
            data_valid_q        <= 1'b0;
            flags_q             <= '0;
            flags_q[FLAG_EMPTY] <= 1'b1;
            flags_q[FLAG_AE]    <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            flags_q      <= flags_d;
        end
    end

    ram_dp_sync #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUMBER (NUMBER)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign data_valid   = data_valid_q;
    assign count        = count_q;
    assign empty        = flags_q[FLAG_EMPTY];
    assign full         = flags_q[FLAG_FULL];
    assign almost_empty = flags_q[FLAG_AE];
    assign almost_full  = flags_q[FLAG_AF];
    assign overflow     = flags_q[FLAG_OVF];
    assign underflow    = flags_q[FLAG_UNF];

endmodule

// File: tb/tb_ram_fifo_sync.sv
// tb/tb_ram_fifo_sync.sv - directed and random scoreboard bench for ram_fifo_sync
module tb_ram_fifo_sync;

    logic       clk;
    logic       reset;
    logic       cs_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic [3:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] model[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;

    ram_fifo_sync dut (
        .clk          (clk),
        .reset        (reset),
        .cs_n         (cs_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] d,
                         input logic csn = 1'b0, input logic rst = 1'b0);
        int   sz;
        logic rd_ok, wr_ok, exp_dv;
        cs_n    = csn;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        reset   = rst;
        sz      = model.size();
        exp_dv  = 1'b0;
        if (rst) begin
            model.delete();
            exp_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = 8'd0;
        end else if (!csn) begin
            rd_ok = r && (sz > 0);
            wr_ok = w && ((sz < 8) || rd_ok);
            if (r && !rd_ok) m_unf = 1'b1;
            if (w && !wr_ok) m_ovf = 1'b1;
            if (rd_ok) begin
                exp_q.push_back(model.pop_front());
                exp_dv = 1'b1;
            end
            if (wr_ok) model.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
        sz    = model.size();
        check("data_valid", 32'(data_valid), 32'(exp_dv));
        if (exp_dv && exp_q.size() > 0) m_dout = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(m_dout));
        check("count", 32'(count), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        check("full", 32'(full), 32'(sz == 8));
        check("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        check("almost_full", 32'(almost_full), 32'(sz >= 6));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        cs_n    = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'd0;
        reset   = 1'b1;
        m_dout  = 8'd0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // 1: basic write/read
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 8'd5);
        cycle(1, 0, 8'd12);
        cycle(1, 0, 8'd36);
        check("t1_count3", 32'(count), 32'd3);
        cycle(0, 1, 0);
        check("t1_first_word", 32'(data_out), 32'd5);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        check("t1_last_word", 32'(data_out), 32'd36);
        cycle(0, 0, 0);

        // 2: fill, overflow, drain
        cycle(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i));
        cycle(1, 0, 8'd9);
        check("t2_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        check("t2_last_word", 32'(data_out), 32'd8);

        // 3: full with simultaneous write and read, then wrap-around drain
        cycle(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i));
        cycle(1, 1, 8'd99);
        check("t3_data_out", 32'(data_out), 32'd1);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        check("t3_wrap_word", 32'(data_out), 32'd99);

        // 4: empty with simultaneous write and read
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 8'd7);
        check("t4_underflow", 32'(underflow), 32'd1);
        cycle(0, 1, 0);
        check("t4_word", 32'(data_out), 32'd7);

        // 5: chip select deasserted
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'(20 + i));
        for (int i = 0; i < 3; i++) cycle(1, 1, 8'hee, 1'b1);
        check("t5_count", 32'(count), 32'd4);

        // 6: reset in the middle of traffic
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(30 + i));
        cycle(0, 1, 0);
        cycle(1, 1, 8'd77, 1'b0, 1'b1);
        check("t6_count", 32'(count), 32'd0);
        cycle(1, 0, 8'd42);
        cycle(0, 1, 0);
        check("t6_word", 32'(data_out), 32'd42);

        // random traffic
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
